// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage (master)
// and an instruction memory of arbitrary latency (slave).
interface if_fetch_stage_if #(
  parameter int ADDR_W  = 32,
  parameter int INSTR_W = 32
);
  logic               req;
  logic [ADDR_W-1:0]  addr;
  logic               ack;
  logic [INSTR_W-1:0] rdata;

  modport master (output req, output addr, input ack, input rdata);
  modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/if_fetch_stage.sv
// Fetch stage with IF/ID pipeline register: variable-latency instruction fetch,
// freeze (hold) and taken-branch flush/redirect handling.
module if_fetch_stage #(
  parameter int                ADDR_W   = 32,
  parameter int                INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                freeze_i,
  input  logic                branch_taken_i,
  input  logic [ADDR_W-1:0]   branch_addr_i,
  if_fetch_stage_if.master    imem,
  output logic [ADDR_W-1:0]   if_id_pc_o,
  output logic [INSTR_W-1:0]  if_id_instr_o,
  output logic                if_id_valid_o,
  output logic                fetch_busy_o
);

  typedef enum logic [1:0] {
    ST_ISSUE = 2'd0,
    ST_HOLD  = 2'd1,
    ST_DROP  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  drop_addr_q, drop_addr_d;
  logic [INSTR_W-1:0] hold_buf_q, hold_buf_d;
  logic [ADDR_W-1:0]  id_pc_q, id_pc_d;
  logic [INSTR_W-1:0] id_instr_q, id_instr_d;
  logic               id_valid_q, id_valid_d;

  logic               req_s;
  logic               ack_s;
  logic [ADDR_W-1:0]  pc_inc_s;

  assign ack_s    = imem.ack & req_s;
  assign pc_inc_s = pc_q + ADDR_W'(4);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_ISSUE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ISSUE: begin
        if (branch_taken_i) begin
          state_d = ack_s ? ST_ISSUE : ST_DROP;
        end else if (ack_s && freeze_i) begin
          state_d = ST_HOLD;
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_HOLD: begin
        if (branch_taken_i || !freeze_i) begin
          state_d = ST_ISSUE;
        end else begin
          state_d = ST_HOLD;
        end
      end
      ST_DROP: begin
        if (ack_s) begin
          state_d = ST_ISSUE;
        end else begin
          state_d = ST_DROP;
        end
      end
      default: state_d = ST_ISSUE;
    endcase
  end

  // Request is suppressed combinationally while reset is held so nothing escapes.
  always_comb begin
    req_s        = rst_n & ((state_q == ST_ISSUE) | (state_q == ST_DROP));
    imem.req     = req_s;
    imem.addr    = (state_q == ST_DROP) ? drop_addr_q : pc_q;
    fetch_busy_o = req_s;
  end

  always_comb begin
    pc_d        = pc_q;
    drop_addr_d = drop_addr_q;
    hold_buf_d  = hold_buf_q;
    id_pc_d     = id_pc_q;
    id_instr_d  = id_instr_q;
    id_valid_d  = id_valid_q;
    case (state_q)
      ST_ISSUE: begin
        if (branch_taken_i) begin
          pc_d        = branch_addr_i;
          drop_addr_d = pc_q;
          hold_buf_d  = '0;
          id_pc_d     = '0;
          id_instr_d  = '0;
          id_valid_d  = 1'b0;
        end else if (ack_s) begin
          if (freeze_i) begin
            hold_buf_d = imem.rdata;
          end else begin
            pc_d       = pc_inc_s;
            id_pc_d    = pc_inc_s;
            id_instr_d = imem.rdata;
            id_valid_d = 1'b1;
          end
        end else if (!freeze_i) begin
          // Decode moves on while the fetch is still waiting: feed it a bubble.
          id_pc_d    = '0;
          id_instr_d = '0;
          id_valid_d = 1'b0;
        end else begin
          id_valid_d = id_valid_q;
        end
      end
      ST_HOLD: begin
        if (branch_taken_i) begin
          pc_d       = branch_addr_i;
          hold_buf_d = '0;
          id_pc_d    = '0;
          id_instr_d = '0;
          id_valid_d = 1'b0;
        end else if (!freeze_i) begin
          pc_d       = pc_inc_s;
          id_pc_d    = pc_inc_s;
          id_instr_d = hold_buf_q;
          id_valid_d = 1'b1;
        end else begin
          id_valid_d = id_valid_q;
        end
      end
      ST_DROP: begin
        if (branch_taken_i) begin
          pc_d = branch_addr_i;
        end else begin
          pc_d = pc_q;
        end
      end
      default: begin
        id_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q        <= RESET_PC;
      drop_addr_q <= '0;
      hold_buf_q  <= '0;
      id_pc_q     <= '0;
      id_instr_q  <= '0;
      id_valid_q  <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      drop_addr_q <= drop_addr_d;
      hold_buf_q  <= hold_buf_d;
      id_pc_q     <= id_pc_d;
      id_instr_q  <= id_instr_d;
      id_valid_q  <= id_valid_d;
    end
  end

  assign if_id_pc_o    = id_pc_q;
  assign if_id_instr_o = id_instr_q;
  assign if_id_valid_o = id_valid_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Randomised self-checking bench for if_fetch_stage: a variable-latency memory
// model drives the main instance; a second zero-wait instance covers PC wrap.
module tb_if_fetch_stage;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        freeze = 1'b0;
  logic        br = 1'b0;
  logic [31:0] baddr = 32'h0;

  logic [31:0] id_pc, id_instr, w_id_pc, w_id_instr;
  logic        id_valid, busy, w_id_valid, w_busy;

  if_fetch_stage_if #(.ADDR_W(32), .INSTR_W(32)) bus ();
  if_fetch_stage_if #(.ADDR_W(32), .INSTR_W(32)) bus_w ();

  assign bus.rdata   = 32'hE000_0000 + bus.addr;
  assign bus_w.ack   = bus_w.req;
  assign bus_w.rdata = 32'hE000_0000 + bus_w.addr;

  if_fetch_stage #(.ADDR_W(32), .INSTR_W(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .freeze_i(freeze), .branch_taken_i(br),
    .branch_addr_i(baddr), .imem(bus), .if_id_pc_o(id_pc),
    .if_id_instr_o(id_instr), .if_id_valid_o(id_valid), .fetch_busy_o(busy));

  if_fetch_stage #(.ADDR_W(32), .INSTR_W(32), .RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .rst_n(rst_n), .freeze_i(freeze), .branch_taken_i(br),
    .branch_addr_i(baddr), .imem(bus_w), .if_id_pc_o(w_id_pc),
    .if_id_instr_o(w_id_instr), .if_id_valid_o(w_id_valid), .fetch_busy_o(w_busy));

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int lat_mode = 1;   // cycles per access; 0 = random 1..4
  int wait_cnt = 0;

  // Reference model: what the fetch unit owes the pipeline, in transaction terms.
  logic [31:0] m_pc, m_buf, m_daddr, m_id_pc, m_id_instr;
  logic        m_have_buf, m_doomed, m_id_valid;

  function automatic void model_reset();
    m_pc = 32'h0; m_buf = 32'h0; m_daddr = 32'h0;
    m_have_buf = 1'b0; m_doomed = 1'b0;
    m_id_pc = 32'h0; m_id_instr = 32'h0; m_id_valid = 1'b0;
  endfunction

  function automatic int next_lat();
    return (lat_mode == 0) ? int'($urandom_range(1, 4)) : lat_mode;
  endfunction

  task automatic step(input logic f, input logic b, input logic [31:0] ba);
    logic        m_req, req_s, ackr;
    logic [31:0] m_addr, rd;
    @(negedge clk);
    m_req  = !m_have_buf;
    m_addr = m_doomed ? m_daddr : m_pc;
    checks++;
    if (bus.req !== m_req) begin
      errors++; $display("FAIL req: got %b expected %b", bus.req, m_req);
    end
    if (m_req) begin
      checks++;
      if (bus.addr !== m_addr) begin
        errors++; $display("FAIL addr: got %h expected %h", bus.addr, m_addr);
      end
    end
    checks++;
    if (busy !== m_req) begin
      errors++; $display("FAIL busy: got %b expected %b", busy, m_req);
    end
    checks++;
    if ({id_pc, id_instr, id_valid} !== {m_id_pc, m_id_instr, m_id_valid}) begin
      errors++;
      $display("FAIL if_id: got %h/%h/%b expected %h/%h/%b",
               id_pc, id_instr, id_valid, m_id_pc, m_id_instr, m_id_valid);
    end
    freeze = f; br = b; baddr = ba;
    req_s = bus.req;
    bus.ack = req_s ? (wait_cnt == 0) : 1'($urandom_range(0, 1));
    ackr = m_req && bus.ack;
    rd = 32'hE000_0000 + m_addr;
    if (m_have_buf) begin
      if (b) begin
        {m_id_pc, m_id_instr, m_id_valid} = '0; m_pc = ba; m_have_buf = 1'b0;
      end else if (!f) begin
        m_id_pc = m_pc + 32'd4; m_id_instr = m_buf; m_id_valid = 1'b1;
        m_pc = m_pc + 32'd4; m_have_buf = 1'b0;
      end
    end else if (m_doomed) begin
      if (b) m_pc = ba;
      if (ackr) m_doomed = 1'b0;
    end else begin
      if (b) begin
        {m_id_pc, m_id_instr, m_id_valid} = '0;
        if (!ackr) begin m_doomed = 1'b1; m_daddr = m_pc; end
        m_pc = ba;
      end else if (ackr) begin
        if (f) begin
          m_have_buf = 1'b1; m_buf = rd;
        end else begin
          m_id_pc = m_pc + 32'd4; m_id_instr = rd; m_id_valid = 1'b1;
          m_pc = m_pc + 32'd4;
        end
      end else if (!f) begin
        {m_id_pc, m_id_instr, m_id_valid} = '0;
      end
    end
    @(posedge clk);
    if (req_s && bus.ack) wait_cnt = next_lat() - 1;
    else if (req_s) wait_cnt = wait_cnt - 1;
    #1;
  endtask

  task automatic do_reset(input int lat);
    @(negedge clk);
    rst_n = 1'b0; freeze = 1'b0; br = 1'b0; bus.ack = 1'b0;
    model_reset();
    lat_mode = lat; wait_cnt = lat - 1;
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    model_reset();
    bus.ack = 1'b0; lat_mode = 1; wait_cnt = 0;
    @(posedge clk); #1;
    checks++;
    if (bus.req !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_req: got %b/%b expected 0/0", bus.req, busy);
    end
    checks++;
    if ({id_pc, id_instr, id_valid} !== 65'h0) begin
      errors++; $display("FAIL reset_if_id: got %h/%h/%b expected 0/0/0", id_pc, id_instr, id_valid);
    end
    #1 rst_n = 1'b1;
    #1;
    checks++;
    if (bus.req !== 1'b1 || bus.addr !== 32'h0) begin
      errors++; $display("FAIL reset_first_req: got %b/%h expected 1/00000000", bus.req, bus.addr);
    end
  endtask

  task automatic test_zero_wait();
    step(1'b0, 1'b0, 32'h0);
    checks++;
    if (id_pc !== 32'd4 || id_valid !== 1'b1) begin
      errors++; $display("FAIL zw_first: got %h/%b expected 00000004/1", id_pc, id_valid);
    end
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    checks++;
    if (id_pc !== 32'd12 || id_instr !== 32'hE000_0008 || id_valid !== 1'b1) begin
      errors++; $display("FAIL zw_third: got %h/%h/%b expected 0000000c/e0000008/1", id_pc, id_instr, id_valid);
    end
  endtask

  task automatic test_latency();
    do_reset(3);
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    checks++;
    if (id_valid !== 1'b0 || bus.addr !== 32'h0 || bus.req !== 1'b1) begin
      errors++; $display("FAIL lat_wait: got valid=%b addr=%h req=%b expected 0/0/1", id_valid, bus.addr, bus.req);
    end
    step(1'b0, 1'b0, 32'h0);
    checks++;
    if ({id_pc, id_instr, id_valid} !== {32'd4, 32'hE000_0000, 1'b1}) begin
      errors++; $display("FAIL lat_data: got %h/%h/%b expected 00000004/e0000000/1", id_pc, id_instr, id_valid);
    end
    step(1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_freeze();
    do_reset(1);
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'h0);
    checks++;
    if (id_pc !== 32'd8 || id_instr !== 32'hE000_0004 || bus.req !== 1'b0) begin
      errors++; $display("FAIL freeze_hold: got %h/%h req=%b expected 00000008/e0000004 req=0", id_pc, id_instr, bus.req);
    end
    step(1'b0, 1'b0, 32'h0);
    checks++;
    if ({id_pc, id_instr, id_valid} !== {32'd12, 32'hE000_0008, 1'b1} || bus.addr !== 32'd12) begin
      errors++; $display("FAIL freeze_release: got %h/%h/%b addr=%h expected 0000000c/e0000008/1 addr=0000000c", id_pc, id_instr, id_valid, bus.addr);
    end
  endtask

  task automatic test_branch();
    do_reset(1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0);
    wait_cnt = 2;
    step(1'b0, 1'b1, 32'h100);
    checks++;
    if (id_valid !== 1'b0 || bus.addr !== 32'h10 || busy !== 1'b1) begin
      errors++; $display("FAIL br_drop: got valid=%b addr=%h busy=%b expected 0/00000010/1", id_valid, bus.addr, busy);
    end
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    checks++;
    if (id_valid !== 1'b0 || bus.addr !== 32'h100) begin
      errors++; $display("FAIL br_redirect: got valid=%b addr=%h expected 0/00000100", id_valid, bus.addr);
    end
    step(1'b0, 1'b0, 32'h0);
    checks++;
    if ({id_pc, id_instr, id_valid} !== {32'h104, 32'hE000_0100, 1'b1}) begin
      errors++; $display("FAIL br_target: got %h/%h/%b expected 00000104/e0000100/1", id_pc, id_instr, id_valid);
    end
  endtask

  task automatic test_branch_in_hold();
    do_reset(1);
    step(1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 32'h200);
    checks++;
    if (id_valid !== 1'b0 || bus.req !== 1'b1 || bus.addr !== 32'h200) begin
      errors++; $display("FAIL hold_branch: got valid=%b req=%b addr=%h expected 0/1/00000200", id_valid, bus.req, bus.addr);
    end
    step(1'b0, 1'b0, 32'h0);
    checks++;
    if ({id_pc, id_instr, id_valid} !== {32'h204, 32'hE000_0200, 1'b1}) begin
      errors++; $display("FAIL hold_branch_fetch: got %h/%h/%b expected 00000204/e0000200/1", id_pc, id_instr, id_valid);
    end
  endtask

  task automatic test_random();
    logic [31:0] ba;
    do_reset(0);
    for (int i = 0; i < 600; i++) begin
      ba = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : $urandom;
      step($urandom_range(0, 9) < 3, $urandom_range(0, 9) == 0, ba);
    end
  endtask

  task automatic test_reset_midwait();
    do_reset(4);
    step(1'b0, 1'b0, 32'h0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.req !== 1'b0 || bus_w.req !== 1'b0 || w_busy !== 1'b0) begin
      errors++; $display("FAIL midwait_req: got %b/%b/%b expected 0/0/0", bus.req, bus_w.req, w_busy);
    end
    checks++;
    if ({w_id_pc, w_id_instr, w_id_valid} !== 65'h0) begin
      errors++; $display("FAIL midwait_clear: got %h/%h/%b expected 0/0/0", w_id_pc, w_id_instr, w_id_valid);
    end
    model_reset(); bus.ack = 1'b0; lat_mode = 1; wait_cnt = 0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    checks++;
    if (bus_w.req !== 1'b1 || bus_w.addr !== 32'hFFFF_FFFC || bus.addr !== 32'h0) begin
      errors++; $display("FAIL restart_addr: got w=%b/%h main=%h expected 1/fffffffc main=00000000", bus_w.req, bus_w.addr, bus.addr);
    end
    step(1'b0, 1'b0, 32'h0);
    checks++;
    if ({w_id_pc, w_id_instr, w_id_valid} !== {32'h0, 32'hDFFF_FFFC, 1'b1} || bus_w.addr !== 32'h0) begin
      errors++; $display("FAIL wrap: got %h/%h/%b addr=%h expected 00000000/dffffffc/1 addr=00000000", w_id_pc, w_id_instr, w_id_valid, bus_w.addr);
    end
    step(1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    bus.ack = 1'b0;
    test_reset();
    test_zero_wait();
    test_latency();
    test_freeze();
    test_branch();
    test_branch_in_hold();
    test_random();
    test_reset_midwait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
